hs32_fetch: RTL and testbench
=============================

// Module: hs32_fetch
// PURPOSE
//  Instruction fetch stage for the HS32 core, directly upstream of decode/exec.
//  Holds the fetch PC and issues word reads to the memory arbiter.
//  Buffers returned instruction words in a small FIFO and presents them to decode with a valid/ready handshake.
//  Honours exec's flush/newpc redirect, discarding stale buffered and in-flight words.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC loaded on reset
//  DEPTH     2              instruction FIFO entries (power of 2, >=2)
// PORTS
//  clk     in   1   12 MHz clock; all state changes on posedge
//  reset   in   1   synchronous, active-low reset (reset==0 resets on clk edge)
//  addr    out  32  memory address (word aligned)
//  dtrm    in   32  memory read data
//  reqm    out  1   memory request; held until accepted
//  rdym    in   1   memory data valid; transfer = reqm && rdym
//  rw_mem  out  1   always 0 (read)
//  instd   out  32  instruction word to decode (FIFO head)
//  reqd    out  1   instd valid (FIFO not empty)
//  rdyd    in   1   decode accepts; pop = reqd && rdyd
//  newpc   in   32  redirect target from exec
//  flush   in   1   redirect strobe from exec, 1-cycle pulse
// BEHAVIOUR
//  Reset: pc=RESET_PC, addr=0, reqm=0, rw_mem=0, FIFO empty, reqd=0, instd=0, state=IDLE.
//   Reset overrides flush and every other input.
//  States:
//   IDLE  if !flush and (count + pending) < DEPTH: reqm<=1, addr<=pc -> WAIT.
//   WAIT  reqm high, addr stable. On reqm&&rdym: push dtrm (unless flush this cycle),
//         pc<=pc+4, reqm<=0 -> IDLE. One idle cycle of reqm between requests.
//   DROP  request outstanding when flush arrived. Keep reqm high until rdym;
//         then discard dtrm, reqm<=0 -> IDLE.
//  Flush, any state: FIFO cleared same edge; pc<={newpc[31:2],2'b00}; any pop that cycle is void.
//   From WAIT without rdym: go to DROP.
//   From WAIT with rdym: discard data, go to IDLE.
//  Flush in DROP: pc reloaded again; remain in DROP.
//  Latency:
//   flush in IDLE at cycle N -> reqm=1, addr=newpc at N+1.
//   accept at cycle M -> reqd=1, instd=word at M+1.
//  Credit rule: never issue unless a slot is guaranteed. Pending (0/1) counts against DEPTH,
//   so push never overflows. Push and pop in the same cycle are both legal.
//  pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  instd/reqd are registered FIFO outputs. instd is held while reqd && !rdyd.
//  An empty FIFO drives reqd=0; instd value is don't-care but stable.
// STRUCTURE
//  Shared constants in hs32_fetchconst.v:
//   state encodings `FS_IDLE, `FS_WAIT, `FS_DROP; instruction word width.
//  One sub-module: hs32_fifo (sync FIFO; WIDTH, DEPTH params; push, pop, clr, count, head).
//   clr has priority over push/pop.
//  Top level holds the FSM, pc, credit logic and the memory interface registers.
// TESTING
//  1. Reset release with rdym tied 1 and rdyd=1:
//     addr 0,4,8 issued; instd = mem[0],mem[4] in order; reqm gaps one cycle.
//  2. rdyd=0 with DEPTH=2:
//     exactly 2 reads; reqm stays 0 afterwards; instd held.
//     Raise rdyd -> words popped and fetch resumes at addr 8.
//  3. flush (newpc=32'h100) while WAIT with rdym delayed 3 cycles:
//     DROP entered; late word discarded; next addr=32'h100; reqd=0 until its data returns.
//  4. flush (newpc=32'h203) coincident with reqm&&rdym and a pop:
//     data discarded, FIFO empty, next addr=32'h200.
//  5. pc=32'hFFFF_FFFC fetched -> next addr 0.
//     Assert reset mid-WAIT -> reqm=0, pc=RESET_PC next edge.

Source files
------------

// File: rtl/hs32_fetch_pkg.sv
// rtl/hs32_fetch_pkg.sv - shared types and constants for the HS32 fetch stage
package hs32_fetch_pkg;

   localparam int INSN_W = 32;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_DROP = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/hs32_fifo.sv
// rtl/hs32_fifo.sv - synchronous FIFO with registered storage; clear beats push/pop
module hs32_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [CW-1:0]    count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         // Storage is left untouched so the head value stays stable while empty.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/hs32_fetch.sv
// rtl/hs32_fetch.sv - HS32 instruction fetch: PC, memory read requests, instruction buffer
module hs32_fetch
   import hs32_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [31:0]       addr,
   input  logic [31:0]       dtrm,
   output logic              reqm,
   input  logic              rdym,
   output logic              rw_mem,
   output logic [INSN_W-1:0] instd,
   output logic              reqd,
   input  logic              rdyd,
   input  logic [31:0]       newpc,
   input  logic              flush
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          reqm_q, reqm_d;
   logic [31:0]   flush_pc;
   logic [CW-1:0] fifo_count;
   logic          fifo_push;
   logic          fifo_pop;

   assign flush_pc  = word_align(newpc);
   assign fifo_push = (state_q == FS_WAIT) && rdym && !flush;
   assign fifo_pop  = reqd && rdyd && !flush;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      reqm_d  = reqm_q;
      case (state_q)
         FS_IDLE: begin
            // Nothing is pending here, so the buffered count alone decides the credit.
            if (flush) begin
               pc_d    = flush_pc;
               addr_d  = flush_pc;
               reqm_d  = 1'b1;
               state_d = FS_WAIT;
            end else if (fifo_count < DEPTH_C) begin
               addr_d  = pc_q;
               reqm_d  = 1'b1;
               state_d = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (flush) begin
               pc_d = flush_pc;
               if (rdym) begin
                  reqm_d  = 1'b0;
                  state_d = FS_IDLE;
               end else begin
                  state_d = FS_DROP;
               end
            end else if (rdym) begin
               pc_d    = pc_q + 32'd4;
               reqm_d  = 1'b0;
               state_d = FS_IDLE;
            end
         end
         FS_DROP: begin
            if (flush) pc_d = flush_pc;
            if (rdym) begin
               reqm_d  = 1'b0;
               state_d = FS_IDLE;
            end
         end
         default: begin
            reqm_d  = 1'b0;
            state_d = FS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FS_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= '0;
         reqm_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         reqm_q  <= reqm_d;
      end
   end

   hs32_fifo #(
      .WIDTH (INSN_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .resetn_i (reset),
      .clr_i    (flush),
      .push_i   (fifo_push),
      .wdata_i  (dtrm),
      .pop_i    (fifo_pop),
      .count_o  (fifo_count),
      .head_o   (instd)
   );

   assign addr   = addr_q;
   assign reqm   = reqm_q;
   assign rw_mem = 1'b0;
   assign reqd   = (fifo_count != '0);

endmodule

// File: tb/tb_hs32_fetch.sv
// tb/tb_hs32_fetch.sv - self-checking bench for hs32_fetch: vector table, corner sequences, random model
module tb_hs32_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, dtrm, instd, newpc;
   logic        reqm, rdym, rw_mem, reqd, rdyd, flush;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hs32_fetch #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .dtrm   (dtrm),
      .reqm   (reqm),
      .rdym   (rdym),
      .rw_mem (rw_mem),
      .instd  (instd),
      .reqd   (reqd),
      .rdyd   (rdyd),
      .newpc  (newpc),
      .flush  (flush)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic m, input logic d, input logic f, input logic [31:0] npc);
      reset = r;
      rdym  = m;
      rdyd  = d;
      flush = f;
      newpc = npc;
      dtrm  = m ? mem_word(addr) : (32'hBAD0_0000 ^ $urandom);
   endtask

   task automatic step(input logic r, input logic m, input logic d, input logic f, input logic [31:0] npc);
      drive(r, m, d, f, npc);
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic        rst_n;
      logic        m;
      logic        d;
      logic        e_reqm;
      logic [31:0] e_addr;
      logic        e_reqd;
      logic [31:0] e_instd;
      logic        c_instd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic m, input logic d, input logic er,
                      input logic [31:0] ea, input logic ed, input logic [31:0] ei, input logic ci);
      vec_t v;
      v.rst_n = r; v.m = m; v.d = d; v.e_reqm = er; v.e_addr = ea;
      v.e_reqd = ed; v.e_instd = ei; v.c_instd = ci;
      vecs.push_back(v);
   endtask

   // random-phase reference model state
   logic [31:0] exp_q[$];
   logic [31:0] next_pc, addr_p;
   logic        req_open, req_stale, reqm_p, xfer_p, exp_reqm;
   int          n_pops;

   initial begin
      // streaming fetch with decode always ready, then decode stalled until the buffer fills
      add(0,1,1, 0,32'h0,0,32'h0,1);
      add(1,1,1, 1,32'h0,0,32'h0,0);
      add(1,1,1, 0,32'h0,1,mem_word(32'h0),1);
      add(1,1,1, 1,32'h4,0,32'h0,0);
      add(1,1,1, 0,32'h4,1,mem_word(32'h4),1);
      add(1,1,1, 1,32'h8,0,32'h0,0);
      add(1,1,1, 0,32'h8,1,mem_word(32'h8),1);
      add(0,1,0, 0,32'h0,0,32'h0,1);
      add(1,1,0, 1,32'h0,0,32'h0,0);
      add(1,1,0, 0,32'h0,1,mem_word(32'h0),1);
      add(1,1,0, 1,32'h4,1,mem_word(32'h0),1);
      add(1,1,0, 0,32'h4,1,mem_word(32'h0),1);
      add(1,1,0, 0,32'h4,1,mem_word(32'h0),1);
      add(1,1,0, 0,32'h4,1,mem_word(32'h0),1);
      add(1,1,1, 0,32'h4,1,mem_word(32'h4),1);
      add(1,1,1, 1,32'h8,0,32'h0,0);
      add(1,1,1, 0,32'h8,1,mem_word(32'h8),1);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].m, vecs[i].d, 1'b0, 32'h0);
         chk1 ($sformatf("vec%0d reqm", i), reqm, vecs[i].e_reqm);
         chk32($sformatf("vec%0d addr", i), addr, vecs[i].e_addr);
         chk1 ($sformatf("vec%0d reqd", i), reqd, vecs[i].e_reqd);
         if (vecs[i].c_instd) chk32($sformatf("vec%0d instd", i), instd, vecs[i].e_instd);
      end

      // flush while waiting, memory answers three cycles later
      step(0,0,1,0,0);
      step(1,0,1,0,0);            chk1("t3 issue", reqm, 1);
      step(1,0,1,1,32'h100);      chk1("t3 drop reqm", reqm, 1); chk32("t3 drop addr", addr, 32'h0);
      step(1,0,1,0,0);            chk1("t3 hold1", reqm, 1); chk32("t3 hold1 addr", addr, 32'h0);
      step(1,0,1,0,0);            chk1("t3 hold2", reqm, 1);
      step(1,1,1,0,0);            chk1("t3 late reqm", reqm, 0); chk1("t3 late reqd", reqd, 0);
      step(1,0,1,0,0);            chk1("t3 redirect reqm", reqm, 1); chk32("t3 redirect addr", addr, 32'h100);
                                  chk1("t3 reqd empty", reqd, 0);
      step(1,1,1,0,0);            chk1("t3 data reqd", reqd, 1); chk32("t3 data", instd, mem_word(32'h100));

      // flush coincident with transfer and pop; then flush from idle
      step(0,0,0,0,0);
      step(1,1,0,0,0);
      step(1,1,0,0,0);
      step(1,0,0,0,0);            chk32("t4 addr4", addr, 32'h4); chk1("t4 reqd", reqd, 1);
      step(1,1,1,1,32'h203);      chk1("t4 reqm", reqm, 0); chk1("t4 empty", reqd, 0);
      step(1,0,1,0,0);            chk1("t4 next reqm", reqm, 1); chk32("t4 next addr", addr, 32'h200);
      step(1,1,0,0,0);            chk32("t4 word", instd, mem_word(32'h200));
      step(1,0,0,1,32'h3F1);      chk1("idle flush reqm", reqm, 1); chk32("idle flush addr", addr, 32'h3F0);
                                  chk1("idle flush reqd", reqd, 0);

      // pc wrap at the top of the address space, then reset in the middle of a read
      step(0,0,1,0,0);
      step(1,0,1,1,32'hFFFF_FFFC); chk32("t5 top addr", addr, 32'hFFFF_FFFC);
      step(1,1,1,0,0);            chk32("t5 top word", instd, mem_word(32'hFFFF_FFFC));
      step(1,1,1,0,0);            chk1("t5 wrap reqm", reqm, 1); chk32("t5 wrap addr", addr, 32'h0);
      step(1,1,1,0,0);
      step(1,0,1,0,0);            chk32("t5 addr4", addr, 32'h4);
      step(0,0,1,0,0);            chk1("t5 rst reqm", reqm, 0); chk32("t5 rst addr", addr, 32'h0);
                                  chk1("t5 rst reqd", reqd, 0);
      step(1,0,1,0,0);            chk1("t5 restart reqm", reqm, 1); chk32("t5 restart addr", addr, 32'h0);

      // randomized traffic against the stream model
      step(0,0,0,0,0);
      exp_q.delete();
      next_pc = 32'h0; req_open = 0; req_stale = 0; reqm_p = 0; xfer_p = 0; exp_reqm = 0;
      addr_p = 32'h0; n_pops = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        m, d, f, xfer;
         logic [31:0] npc;
         chk1("rand rw_mem", rw_mem, 1'b0);
         chk1("rand reqd", reqd, exp_q.size() != 0);
         chk1("rand reqm", reqm, exp_reqm);
         if (reqm_p && !xfer_p) chk32("rand addr held", addr, addr_p);
         if (reqm && !req_open) begin
            chk32("rand fetch addr", addr, next_pc);
            req_open  = 1;
            req_stale = 0;
         end
         m   = ($urandom_range(0, 2) != 0);
         d   = ($urandom_range(0, 2) != 0);
         f   = ($urandom_range(0, 24) == 0);
         npc = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
         xfer = reqm && m;
         exp_reqm = reqm ? !xfer : (f || exp_q.size() < DEPTH);
         if (reqd && d && !f && exp_q.size() != 0) begin
            chk32("rand instd", instd, exp_q[0]);
            void'(exp_q.pop_front());
            n_pops++;
         end
         if (f) begin
            exp_q.delete();
            next_pc = npc & ~32'h3;
            if (req_open) req_stale = 1;
         end
         if (xfer) begin
            if (!f && !req_stale) begin
               exp_q.push_back(mem_word(addr));
               next_pc = next_pc + 32'd4;
            end
            req_open  = 0;
            req_stale = 0;
         end
         chk1("rand credit", exp_q.size() <= DEPTH, 1'b1);
         reqm_p = reqm;
         xfer_p = xfer;
         addr_p = addr;
         step(1, m, d, f, npc);
      end
      chk1("rand progress", n_pops > 200, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
